rom_rd_ctrl: RTL and testbench

- Frame-read sequencer for the block-ROM reader (rom_rd).
- On start, issues one ROM read enable per pixel of a configured W x H image, in raster order. Honours downstream readiness and emits pixel-position markers aligned to the reader's 2-cycle data-valid latency.
- At frame end, pulses the reader's done input so its address counter returns to 0.
- Sits between the top-level scaling FSM and rom_rd, feeding the down/up-scaler.

---
 rtl/rom_rd_ctrl_pkg.sv | 21 ++
 rtl/rom_rd_marker_pipe.sv | 38 +++
 rtl/rom_rd_ctrl.sv | 154 +++++++++++++++
 tb/tb_rom_rd_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_rd_ctrl_pkg.sv
// Shared types and defaults for the frame-read sequencer in front of rom_rd.
package rom_rd_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DIM_WIDTH  = 9;
   localparam int DEF_RD_LAT     = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_FLUSH,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } marker_t;

endpackage

// File: rtl/rom_rd_marker_pipe.sv
// Delays pixel-position markers by the reader's data-valid latency.
module rom_rd_marker_pipe
   import rom_rd_ctrl_pkg::*;
#(
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_valid,
   input  marker_t i_mk,
   output logic    o_valid,
   output marker_t o_mk
);

   logic [RD_LAT-1:0] r_vld;
   marker_t           r_mk [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_mk[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_valid;
         // markers only enter alongside a real read
         r_mk[0]  <= i_valid ? i_mk : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_mk[i]  <= r_mk[i-1];
         end
      end
   end

   assign o_valid = r_vld[RD_LAT-1];
   assign o_mk    = o_valid ? r_mk[RD_LAT-1] : '0;

endmodule

// File: rtl/rom_rd_ctrl.sv
// Frame-read sequencer: raster-order ROM read enables, done pulse, and
// position markers aligned with the reader's data-valid output.
module rom_rd_ctrl
   import rom_rd_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
   parameter int RD_LAT     = DEF_RD_LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [DIM_WIDTH-1:0] img_w_i,
   input  logic [DIM_WIDTH-1:0] img_h_i,
   input  logic                 ds_ready_i,
   output logic                 rd_en_o,
   output logic                 rd_done_o,
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic                 aborted_o,
   output logic                 sof_o,
   output logic                 eol_o,
   output logic                 eof_o
);

   localparam int FW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

   if (2 * (DIM_WIDTH - 1) > ADDR_WIDTH) begin : g_cfg_chk
      $error("rom_rd_ctrl: max W*H exceeds ROM address space");
   end

   state_t               r_state;
   state_t               w_next;
   logic [DIM_WIDTH-1:0] r_col;
   logic [DIM_WIDTH-1:0] r_row;
   logic [DIM_WIDTH-1:0] r_w_m1;
   logic [DIM_WIDTH-1:0] r_h_m1;
   logic [FW-1:0]        r_flush;
   logic                 r_aborted;
   logic                 w_start;
   logic                 w_rd;
   logic                 w_abort;
   logic                 w_eol;
   logic                 w_last;
   logic                 w_zero;
   logic                 w_pv;
   marker_t              w_mk;
   marker_t              w_pmk;

   assign w_start = (r_state == ST_IDLE) && start_i;
   assign w_abort = (r_state == ST_READ) && abort_i;
   assign w_eol   = (r_col == r_w_m1);
   assign w_last  = w_eol && (r_row == r_h_m1);
   assign w_zero  = (img_w_i == '0) || (img_h_i == '0);

   always_comb begin
      w_next       = r_state;
      w_rd         = 1'b0;
      rd_done_o    = 1'b0;
      frame_done_o = 1'b0;
      busy_o       = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               w_next = w_zero ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            // abort outranks ready and suppresses the read that cycle
            w_rd = ds_ready_i && !abort_i;
            if (abort_i || (w_rd && w_last)) begin
               w_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (r_flush == FW'(RD_LAT - 1)) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            rd_done_o    = 1'b1;
            frame_done_o = 1'b1;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_w_m1    <= '0;
         r_h_m1    <= '0;
         r_flush   <= '0;
         r_aborted <= 1'b0;
      end else begin
         if (w_start) begin
            r_col     <= '0;
            r_row     <= '0;
            r_w_m1    <= img_w_i - 1'b1;
            r_h_m1    <= img_h_i - 1'b1;
            r_aborted <= 1'b0;
         end else if (w_rd) begin
            if (w_eol) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_abort) begin
            r_aborted <= 1'b1;
         end
         if (r_state == ST_FLUSH) begin
            r_flush <= r_flush + 1'b1;
         end else begin
            r_flush <= '0;
         end
      end
   end

   assign w_mk.sof = (r_col == '0) && (r_row == '0);
   assign w_mk.eol = w_eol;
   assign w_mk.eof = w_last;

   rom_rd_marker_pipe #(
      .RD_LAT (RD_LAT)
   ) u_mk_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd),
      .i_mk    (w_mk),
      .o_valid (w_pv),
      .o_mk    (w_pmk)
   );

   assign rd_en_o   = w_rd;
   assign aborted_o = r_aborted;
   assign sof_o     = w_pv && w_pmk.sof;
   assign eol_o     = w_pv && w_pmk.eol;
   assign eof_o     = w_pv && w_pmk.eof;

endmodule

// File: tb/tb_rom_rd_ctrl.sv
// Directed bench for rom_rd_ctrl with a reader-latency and address model.
module tb_rom_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       abort_i;
   logic [8:0] img_w_i;
   logic [8:0] img_h_i;
   logic       ds_ready_i;
   logic       rd_en_o;
   logic       rd_done_o;
   logic       busy_o;
   logic       frame_done_o;
   logic       aborted_o;
   logic       sof_o;
   logic       eol_o;
   logic       eof_o;

   int n_cmp = 0;
   int n_err = 0;

   rom_rd_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .img_w_i      (img_w_i),
      .img_h_i      (img_h_i),
      .ds_ready_i   (ds_ready_i),
      .rd_en_o      (rd_en_o),
      .rd_done_o    (rd_done_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .aborted_o    (aborted_o),
      .sof_o        (sof_o),
      .eol_o        (eol_o),
      .eof_o        (eof_o)
   );

   initial forever #5 clk = ~clk;

   // monitor: models 2-cycle data valid and the reader's address counter
   int cyc_n = 0;
   int nrd = 0;
   int vidx = 0;
   int ndone = 0;
   int done_cyc = 0;
   int stray = 0;
   int pulse_mis = 0;
   int addr = 0;
   int addr_at_done = 0;
   int first_addr = -1;
   logic d1 = 1'b0;
   logic d2 = 1'b0;
   logic v;
   int rd_cyc[$];
   int sof_q[$];
   int eol_q[$];
   int eof_q[$];

   always @(negedge clk) begin
      cyc_n++;
      if (!rst_n) begin
         d1 = 1'b0;
         d2 = 1'b0;
         addr = 0;
      end else begin
         v  = d2;
         d2 = d1;
         d1 = rd_en_o;
         if (start_i) begin
            nrd = 0;
            vidx = 0;
            ndone = 0;
            first_addr = -1;
            rd_cyc.delete();
            sof_q.delete();
            eol_q.delete();
            eof_q.delete();
         end
         if (v) begin
            vidx++;
            if (sof_o) sof_q.push_back(vidx);
            if (eol_o) eol_q.push_back(vidx);
            if (eof_o) eof_q.push_back(vidx);
         end else if (sof_o || eol_o || eof_o) begin
            stray++;
         end
         if (rd_en_o) begin
            if (nrd == 0) first_addr = addr;
            rd_cyc.push_back(cyc_n);
            nrd++;
            addr++;
         end
         if (rd_done_o) begin
            addr_at_done = addr;
            addr = 0;
            ndone++;
            done_cyc = cyc_n;
         end
         if (rd_done_o !== frame_done_o) pulse_mis++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic start_frame(input int w, input int h, input logic ab);
      img_w_i = 9'(w);
      img_h_i = 9'(h);
      start_i = 1'b1;
      abort_i = ab;
      cyc();
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      int k = 0;
      while (ndone == 0 && k < lim) begin
         cyc();
         k++;
      end
      check(tag, ndone, 1);
   endtask

   task automatic wait_reads(input string tag, input int n, input int lim);
      int k = 0;
      while (nrd < n && k < lim) begin
         cyc();
         k++;
      end
      check(tag, nrd, n);
   endtask

   initial begin
      rst_n      = 1'b0;
      start_i    = 1'b0;
      abort_i    = 1'b0;
      img_w_i    = '0;
      img_h_i    = '0;
      ds_ready_i = 1'b1;
      repeat (3) cyc();
      check("reset outs", {rd_en_o, rd_done_o, busy_o, frame_done_o,
                           aborted_o, sof_o, eol_o, eof_o}, 0);
      rst_n = 1'b1;
      cyc();

      // 4x2 unstalled
      start_frame(4, 2, 1'b0);
      check("t1 busy", busy_o, 1);
      wait_done("t1 done", 100);
      check("t1 busy low", busy_o, 0);
      check("t1 nrd", nrd, 8);
      check("t1 contig", rd_cyc[7] - rd_cyc[0], 7);
      check("t1 sof n", sof_q.size(), 1);
      check("t1 sof", sof_q[0], 1);
      check("t1 eol n", eol_q.size(), 2);
      check("t1 eol a", eol_q[0], 4);
      check("t1 eol b", eol_q[1], 8);
      check("t1 eof n", eof_q.size(), 1);
      check("t1 eof", eof_q[0], 8);
      check("t1 done lat", done_cyc - rd_cyc[7], 3);
      check("t1 aborted", aborted_o, 0);

      // 3x3 with a 5-cycle stall after the 4th read
      start_frame(3, 3, 1'b0);
      wait_reads("t2 nrd4", 4, 50);
      ds_ready_i = 1'b0;
      repeat (5) cyc();
      check("t2 stall hold", nrd, 4);
      ds_ready_i = 1'b1;
      wait_done("t2 done", 100);
      check("t2 nrd", nrd, 9);
      check("t2 gap", rd_cyc[4] - rd_cyc[3], 6);
      check("t2 tail", rd_cyc[8] - rd_cyc[4], 4);
      check("t2 sof", sof_q[0], 1);
      check("t2 eol n", eol_q.size(), 3);
      check("t2 eol a", eol_q[0], 3);
      check("t2 eol b", eol_q[1], 6);
      check("t2 eol c", eol_q[2], 9);
      check("t2 eof", eof_q[0], 9);
      check("t2 eof n", eof_q.size(), 1);

      // zero width: no reads, immediate done
      start_frame(0, 5, 1'b0);
      check("t4 done now", rd_done_o, 1);
      check("t4 busy", busy_o, 1);
      wait_done("t4 done", 20);
      check("t4 nrd", nrd, 0);
      check("t4 busy low", busy_o, 0);

      // 8x8 aborted after read 10
      start_frame(8, 8, 1'b0);
      wait_reads("t5 nrd10", 10, 50);
      abort_i = 1'b1;
      #1;
      check("t5 abort drop", rd_en_o, 0);
      cyc();
      abort_i = 1'b0;
      check("t5 aborted", aborted_o, 1);
      wait_done("t5 done", 50);
      check("t5 nrd", nrd, 10);
      check("t5 no eof", eof_q.size(), 0);
      check("t5 done lat", done_cyc - rd_cyc[9], 4);
      repeat (3) cyc();
      check("t5 sticky", aborted_o, 1);

      // 1x1 with simultaneous start+abort: start wins
      start_frame(1, 1, 1'b1);
      check("t5b clr", aborted_o, 0);
      wait_done("t5b done", 20);
      check("t5b nrd", nrd, 1);
      check("t5b sof", sof_q.size(), 1);
      check("t5b eol", eol_q.size(), 1);
      check("t5b eof", eof_q.size(), 1);
      check("t5b aborted", aborted_o, 0);

      // reset mid-frame
      start_frame(8, 8, 1'b0);
      wait_reads("t6 nrd20", 20, 60);
      rst_n = 1'b0;
      #1;
      check("t6 async", {rd_en_o, rd_done_o, busy_o, frame_done_o,
                         aborted_o, sof_o, eol_o, eof_o}, 0);
      repeat (4) cyc();
      check("t6 no done", ndone, 0);
      rst_n = 1'b1;
      cyc();
      start_frame(8, 8, 1'b0);
      wait_done("t6 done", 200);
      check("t6 nrd", nrd, 64);
      check("t6 first addr", first_addr, 0);
      check("t6 eol n", eol_q.size(), 8);
      check("t6 eof", eof_q[0], 64);

      // full 256x256 frame, then a second start from address 0
      start_frame(256, 256, 1'b0);
      wait_done("t3 done", 70000);
      check("t3 nrd", nrd, 65536);
      check("t3 addr", addr_at_done, 65536);
      check("t3 eof n", eof_q.size(), 1);
      check("t3 eof", eof_q[0], 65536);
      check("t3 eol n", eol_q.size(), 256);
      check("t3 sof n", sof_q.size(), 1);
      start_frame(2, 2, 1'b0);
      wait_done("t3b done", 50);
      check("t3b first addr", first_addr, 0);
      check("t3b nrd", nrd, 4);

      check("stray markers", stray, 0);
      check("done/frame_done", pulse_mis, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
